// File: rtl/bram_sp_dma_pkg.sv
// Shared types for the single-port BRAM block-transfer controller.
package bram_sp_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_RD_OUT   = 3'd4
  } state_e;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

endpackage

// File: rtl/bram_sp_dma_chksum.sv
// Modulo-2**pWidth running sum of transferred words; cleared when a transfer is accepted.
module bram_sp_dma_chksum #(
  parameter int pWidth = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [pWidth-1:0] data_i,
  output logic [pWidth-1:0] sum_o
);

  logic [pWidth-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + data_i;
    end else begin
      sum_d = sum_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/bram_sp_dma.sv
// Block mover between a valid/ready stream and a contiguous single-port BRAM region.
// Define BRAM_SP_DMA_CHKSUM_EN to build the transfer checksum; otherwise Chksum is 0.
module bram_sp_dma
  import bram_sp_dma_pkg::*;
#(
  parameter int pAddrWidth = 11,
  parameter int pWidth     = 8,
  parameter int pLenWidth  = 12
) (
  input  logic                  Clk,
  input  logic                  Rst_N,
  input  logic                  Start,
  input  logic                  Dir,
  input  logic [pAddrWidth-1:0] BaseAddr,
  input  logic [pLenWidth-1:0]  Len,
  input  logic                  Abort,
  output logic                  Busy,
  output logic                  Done,
  input  logic [pWidth-1:0]     WrData,
  input  logic                  WrVld,
  output logic                  WrRdy,
  output logic [pWidth-1:0]     RdData,
  output logic                  RdVld,
  input  logic                  RdRdy,
  output logic                  CE,
  output logic                  WE,
  output logic [pAddrWidth-1:0] PA,
  output logic [pWidth-1:0]     DI,
  input  logic [pWidth-1:0]     DO,
  output logic [pWidth-1:0]     Chksum
);

  state_e                state_q, state_d;
  logic [pAddrWidth-1:0] addr_q, addr_d;
  logic [pLenWidth-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [pWidth-1:0]     rddata_q, rddata_d;

  logic start_ok, wr_hs, rd_hs, last_word;

  // Abort outranks Start and both handshakes in the same cycle.
  assign start_ok  = (state_q == ST_IDLE) && Start && !Abort;
  assign wr_hs     = (state_q == ST_WR) && WrVld && !Abort;
  assign rd_hs     = (state_q == ST_RD_OUT) && RdRdy && !Abort;
  assign last_word = (cnt_q == pLenWidth'(1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    rddata_d = rddata_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          addr_d = BaseAddr;
          cnt_d  = Len;
          if (Len == '0) begin
            done_d = 1'b1;
          end else if (Dir == DIR_RD) begin
            state_d = ST_RD_ISSUE;
          end else begin
            state_d = ST_WR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (wr_hs) begin
          addr_d = addr_q + pAddrWidth'(1);
          cnt_d  = cnt_q - pLenWidth'(1);
          if (last_word) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WR;
          end
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD_ISSUE: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_CAPT;
        end
      end
      ST_RD_CAPT: begin
        // DO is only driven while CE is high, so it is captured while still enabled.
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          rddata_d = DO;
          state_d  = ST_RD_OUT;
        end
      end
      ST_RD_OUT: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (rd_hs) begin
          addr_d = addr_q + pAddrWidth'(1);
          cnt_d  = cnt_q - pLenWidth'(1);
          if (last_word) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end else begin
          state_d = ST_RD_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rddata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rddata_q <= rddata_d;
    end
  end

  assign Busy   = (state_q != ST_IDLE);
  assign Done   = done_q;
  assign WrRdy  = (state_q == ST_WR) && !Abort;
  assign RdVld  = (state_q == ST_RD_OUT) && !Abort;
  assign CE     = wr_hs || (state_q == ST_RD_ISSUE) || (state_q == ST_RD_CAPT);
  assign WE     = wr_hs;
  assign PA     = Busy ? addr_q : '0;
  assign DI     = (state_q == ST_WR) ? WrData : '0;
  assign RdData = rddata_q;

`ifdef BRAM_SP_DMA_CHKSUM_EN
  bram_sp_dma_chksum #(
    .pWidth (pWidth)
  ) u_chksum (
    .clk_i  (Clk),
    .rst_ni (Rst_N),
    .clr_i  (start_ok),
    .en_i   (wr_hs || rd_hs),
    .data_i (wr_hs ? WrData : rddata_q),
    .sum_o  (Chksum)
  );
`else
  assign Chksum = '0;
`endif

endmodule

// File: tb/tb_bram_sp_dma.sv
// Scoreboard bench for bram_sp_dma: stimulus pushes expected BRAM accesses, stream
// words and Done pulses; negedge monitors pop and compare against a reference memory.
module tb_bram_sp_dma;

  localparam int AW = 11;
  localparam int W  = 8;
  localparam int LW = 12;

  logic          Clk = 1'b0;
  logic          Rst_N;
  logic          Start, Dir, Abort;
  logic [AW-1:0] BaseAddr;
  logic [LW-1:0] Len;
  logic          Busy, Done;
  logic [W-1:0]  WrData;
  logic          WrVld, WrRdy;
  logic [W-1:0]  RdData;
  logic          RdVld, RdRdy;
  logic          CE, WE;
  logic [AW-1:0] PA;
  logic [W-1:0]  DI, DO;
  logic [W-1:0]  Chksum;

  bram_sp_dma #(.pAddrWidth(AW), .pWidth(W), .pLenWidth(LW)) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Start(Start), .Dir(Dir), .BaseAddr(BaseAddr),
    .Len(Len), .Abort(Abort), .Busy(Busy), .Done(Done), .WrData(WrData),
    .WrVld(WrVld), .WrRdy(WrRdy), .RdData(RdData), .RdVld(RdVld), .RdRdy(RdRdy),
    .CE(CE), .WE(WE), .PA(PA), .DI(DI), .DO(DO), .Chksum(Chksum)
  );

  always #5 Clk = ~Clk;

  // Single-port BRAM responder: registered read, output gated by CE.
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] dout_r;
  always @(posedge Clk) begin
    if (CE) begin
      if (WE) mem[PA] <= DI;
      dout_r <= mem[PA];
    end
  end
  assign DO = CE ? dout_r : '0;

  typedef struct { logic [AW-1:0] a; logic [W-1:0] d; } wr_t;
  wr_t           exp_wr[$];
  logic [W-1:0]  exp_rd[$];
  logic [AW-1:0] exp_ra[$];
  logic [W-1:0]  wbuf[$];
  logic [W-1:0]  ref_mem [0:(1<<AW)-1];
  int            exp_done, done_seen;
  int            errors, checks;
  logic          prev_rd_ce;
  logic [AW-1:0] last_pa;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ck(input logic [W-1:0] s);
`ifdef BRAM_SP_DMA_CHKSUM_EN
    return s;
`else
    return 8'h00;
`endif
  endfunction

  // Monitor: every BRAM access and stream handshake must match the next expectation.
  always @(negedge Clk) begin
    if (!Rst_N) begin
      prev_rd_ce <= 1'b0;
    end else begin
      if (CE && WE) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: WE at PA=0x%0h DI=0x%0h, none expected", PA, DI);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_pa", PA, e.a);
          check("wr_di", DI, e.d);
        end
      end
      if (CE && !WE) begin
        if (!prev_rd_ce) begin
          if (exp_ra.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: read CE at PA=0x%0h, none expected", PA);
          end else begin
            check("rd_pa", PA, exp_ra.pop_front());
          end
        end else begin
          check("rd_pa_hold", PA, last_pa);
        end
      end
      prev_rd_ce <= CE && !WE;
      last_pa    <= PA;
      if (RdVld && RdRdy) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_extra: RdData=0x%0h delivered, none expected", RdData);
        end else begin
          check("rd_data", RdData, exp_rd.pop_front());
        end
      end
      if (Done) begin
        done_seen++;
        check("done_busy", Busy, 0);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_xfer(input logic dir, input logic [AW-1:0] base, input logic [LW-1:0] len);
    Start = 1'b1; Dir = dir; BaseAddr = base; Len = len;
    tick();
    Start = 1'b0;
  endtask

  task automatic wr_xfer(input logic [AW-1:0] base, input int len, input int max_gap,
                         input bit inject, input int rst_after);
    int nwr;
    int gap;
    logic [W-1:0] sum;
    nwr = (rst_after < 0) ? len : rst_after;
    sum = '0;
    for (int i = 0; i < nwr; i++) begin
      wr_t e;
      e.a = base + AW'(i);
      e.d = wbuf[i];
      exp_wr.push_back(e);
      ref_mem[e.a] = e.d;
      sum = sum + wbuf[i];
    end
    if (rst_after < 0) exp_done++;
    start_xfer(1'b0, base, LW'(len));
    check("wr_busy", Busy, 1);
    for (int i = 0; i < len; i++) begin
      if (i == rst_after) begin
        WrVld = 1'b1; WrData = 8'hFF; Rst_N = 1'b0;
        #1;
        check("rst_ctl", {26'd0, Busy, Done, WrRdy, RdVld, CE, WE}, 0);
        check("rst_pa", PA, 0);
        check("rst_di", DI, 0);
        check("rst_rddata", RdData, 0);
        check("rst_chksum", Chksum, 0);
        WrVld = 1'b0;
        tick(); tick();
        Rst_N = 1'b1;
        tick();
        return;
      end
      gap = (i == 0) ? 0 : $urandom_range(0, max_gap);
      if (inject && i == 1 && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        WrVld = 1'b0;
        if (inject && g == 0) begin
          Start = 1'b1; Dir = 1'b1; BaseAddr = 11'h555; Len = 12'd7;
        end
        tick();
        Start = 1'b0;
      end
      WrVld = 1'b1; WrData = wbuf[i];
      check("wr_rdy", WrRdy, 1);
      tick();
    end
    WrVld = 1'b0;
    check("wr_done", Done, 1);
    check("wr_idle", Busy, 0);
    check("wr_chksum", Chksum, ck(sum));
    tick();
    check("wr_done_pulse", Done, 0);
    check("wr_stays_idle", Busy, 0);
  endtask

  task automatic rd_xfer(input logic [AW-1:0] base, input int len, input int max_stall,
                         input int stall_idx, input int stall_n, input int abort_at);
    int nout, nacc, stall, lat;
    logic [W-1:0] sum, d0;
    nout = (abort_at < 0) ? len : abort_at;
    nacc = (abort_at < 0) ? len : abort_at + 1;
    sum = '0;
    for (int i = 0; i < nacc; i++) exp_ra.push_back(base + AW'(i));
    for (int i = 0; i < nout; i++) begin
      exp_rd.push_back(ref_mem[base + AW'(i)]);
      sum = sum + ref_mem[base + AW'(i)];
    end
    if (abort_at < 0) exp_done++;
    RdRdy = 1'b0;
    start_xfer(1'b1, base, LW'(len));
    for (int i = 0; i < len; i++) begin
      stall = (i == stall_idx) ? stall_n : $urandom_range(0, max_stall);
      RdRdy = (stall == 0);
      lat = 0;
      while (!RdVld && lat < 20) begin
        tick();
        lat++;
      end
      if (!RdVld) begin
        checks++; errors++;
        $display("FAIL rd_timeout: RdVld absent for 20 cycles on word %0d", i);
        RdRdy = 1'b0;
        return;
      end
      check("rd_latency", lat, 2);
      if (i == abort_at) begin
        RdRdy = 1'b1; Abort = 1'b1;
        tick();
        Abort = 1'b0; RdRdy = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_rdvld", RdVld, 0);
        check("abort_done", Done, 0);
        check("abort_chksum", Chksum, ck(sum));
        tick();
        check("abort_no_done", Done, 0);
        return;
      end
      if (stall > 0) begin
        d0 = RdData;
        for (int s = 0; s < stall; s++) begin
          tick();
          check("stall_vld", RdVld, 1);
          check("stall_data", RdData, d0);
          check("stall_ce", CE, 0);
        end
        RdRdy = 1'b1;
      end
      tick();
    end
    RdRdy = 1'b0;
    check("rd_done", Done, 1);
    check("rd_idle", Busy, 0);
    check("rd_chksum", Chksum, ck(sum));
    tick();
    check("rd_done_pulse", Done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] b;
    int            n;
    errors = 0; checks = 0; exp_done = 0; done_seen = 0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    Rst_N = 1'b0; Start = 1'b0; Dir = 1'b0; BaseAddr = '0; Len = '0; Abort = 1'b0;
    WrData = '0; WrVld = 1'b0; RdRdy = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_ctl", {26'd0, Busy, Done, WrRdy, RdVld, CE, WE}, 0);
    check("reset_pa", PA, 0);
    check("reset_chksum", Chksum, 0);
    Rst_N = 1'b1;
    tick();

    wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_xfer(11'h010, 4, 0, 1'b0, -1);
    rd_xfer(11'h010, 4, 0, -1, 0, -1);

    wbuf = '{8'hA5, 8'h5A, 8'hC3};
    wr_xfer(11'h7FE, 3, 0, 1'b0, -1);
    rd_xfer(11'h7FE, 3, 0, -1, 0, -1);

    wbuf.delete();
    for (int i = 0; i < 6; i++) wbuf.push_back(W'($urandom));
    wr_xfer(11'h200, 6, 2, 1'b1, -1);
    rd_xfer(11'h200, 6, 0, 2, 5, -1);

    exp_done++;
    start_xfer(1'b0, 11'h100, 12'd0);
    check("len0_done", Done, 1);
    check("len0_busy", Busy, 0);
    check("len0_ce", CE, 0);
    check("len0_chksum", Chksum, 0);
    tick();
    check("len0_pulse", Done, 0);
    check("len0_idle", Busy, 0);

    rd_xfer(11'h010, 4, 0, -1, 0, 1);

    wbuf = '{8'h01, 8'h02, 8'h03, 8'h04};
    wr_xfer(11'h300, 4, 0, 1'b0, 2);

    for (int it = 0; it < 8; it++) begin
      b = AW'($urandom_range(0, (1 << AW) - 1));
      n = $urandom_range(1, 6);
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back(W'($urandom));
      wr_xfer(b, n, 2, 1'b0, -1);
      rd_xfer(b, n, 3, -1, 0, -1);
    end

    tick();
    check("left_wr", exp_wr.size(), 0);
    check("left_rd", exp_rd.size(), 0);
    check("left_ra", exp_ra.size(), 0);
    check("done_count", done_seen, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
